// File: rtl/reg_hazard_tracker.sv
// rtl/reg_hazard_tracker.sv - ID-stage tracker of in-flight register writes driving forwarding selects and load-use stall
module reg_hazard_tracker #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PIPE_DEPTH     = 3,
  parameter int LOAD_READY     = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              hold,
  input  logic                              id_valid,
  input  logic                              id_read_en_1,
  input  logic [REG_ADDR_WIDTH-1:0]         id_read_addr_1,
  input  logic                              id_read_en_2,
  input  logic [REG_ADDR_WIDTH-1:0]         id_read_addr_2,
  input  logic                              id_write_en,
  input  logic [REG_ADDR_WIDTH-1:0]         id_write_addr,
  input  logic                              id_is_load,
  output logic                              stall_req,
  output logic [$clog2(PIPE_DEPTH+1)-1:0]   fwd_sel_1,
  output logic [$clog2(PIPE_DEPTH+1)-1:0]   fwd_sel_2,
  output logic [CNT_WIDTH-1:0]              stall_count
);

  localparam int FSEL_W = $clog2(PIPE_DEPTH+1);

  logic [PIPE_DEPTH-1:0]     r_valid;
  logic [PIPE_DEPTH-1:0]     r_is_load;
  logic [REG_ADDR_WIDTH-1:0] r_addr [PIPE_DEPTH];
  logic [CNT_WIDTH-1:0]      r_stall_count;

  logic w_early_load_1;
  logic w_early_load_2;
  logic w_track;

  // Scan oldest to youngest so the youngest matching entry overwrites the result last.
  always_comb begin
    fwd_sel_1      = '0;
    fwd_sel_2      = '0;
    w_early_load_1 = 1'b0;
    w_early_load_2 = 1'b0;
    for (int i = PIPE_DEPTH-1; i >= 0; i--) begin
      if (id_read_en_1 && (id_read_addr_1 != '0) && r_valid[i] && (r_addr[i] == id_read_addr_1)) begin
        fwd_sel_1      = FSEL_W'(i + 1);
        w_early_load_1 = r_is_load[i] && (i < LOAD_READY);
      end
      if (id_read_en_2 && (id_read_addr_2 != '0) && r_valid[i] && (r_addr[i] == id_read_addr_2)) begin
        fwd_sel_2      = FSEL_W'(i + 1);
        w_early_load_2 = r_is_load[i] && (i < LOAD_READY);
      end
    end
  end

  assign stall_req   = id_valid && (w_early_load_1 || w_early_load_2);
  assign w_track     = id_valid && id_write_en && (id_write_addr != '0) && !stall_req;
  assign stall_count = r_stall_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid       <= '0;
      r_is_load     <= '0;
      r_stall_count <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        r_addr[i] <= '0;
      end
    end else begin
      if (stall_req && !hold && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + CNT_WIDTH'(1);
      end
      if (flush) begin
        r_valid <= '0;
      end else if (!hold) begin
        for (int i = PIPE_DEPTH-1; i > 0; i--) begin
          r_valid[i]   <= r_valid[i-1];
          r_addr[i]    <= r_addr[i-1];
          r_is_load[i] <= r_is_load[i-1];
        end
        // A stalled ID instruction re-presents next cycle, so EX receives a bubble now.
        r_valid[0]   <= w_track;
        r_addr[0]    <= id_write_addr;
        r_is_load[0] <= id_is_load;
      end
    end
  end

endmodule

// File: tb/tb_reg_hazard_tracker.sv
// tb/tb_reg_hazard_tracker.sv - randomized and directed check of reg_hazard_tracker against a queue model
module tb_reg_hazard_tracker;

  localparam int AW      = 5;
  localparam int PD      = 3;
  localparam int LR      = 1;
  localparam int CW      = 4;
  localparam int FW      = $clog2(PD+1);
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush, hold, id_valid;
  logic          id_read_en_1, id_read_en_2, id_write_en, id_is_load;
  logic [AW-1:0] id_read_addr_1, id_read_addr_2, id_write_addr;
  logic          stall_req;
  logic [FW-1:0] fwd_sel_1, fwd_sel_2;
  logic [CW-1:0] stall_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_hazard_tracker #(
    .REG_ADDR_WIDTH(AW), .PIPE_DEPTH(PD), .LOAD_READY(LR), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold), .id_valid(id_valid),
    .id_read_en_1(id_read_en_1), .id_read_addr_1(id_read_addr_1),
    .id_read_en_2(id_read_en_2), .id_read_addr_2(id_read_addr_2),
    .id_write_en(id_write_en), .id_write_addr(id_write_addr), .id_is_load(id_is_load),
    .stall_req(stall_req), .fwd_sel_1(fwd_sel_1), .fwd_sel_2(fwd_sel_2),
    .stall_count(stall_count)
  );

  // Model: list of in-flight writes, index 0 = youngest (EX).
  typedef struct { bit v; int a; bit ld; } ent_t;
  ent_t m_q[$];
  int   m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int m_sel(input bit en, input int addr);
    if (!en || addr == 0) return 0;
    foreach (m_q[i]) if (m_q[i].v && m_q[i].a == addr) return i + 1;
    return 0;
  endfunction

  function automatic bit m_stall();
    int s1 = m_sel(id_read_en_1, int'(id_read_addr_1));
    int s2 = m_sel(id_read_en_2, int'(id_read_addr_2));
    bit s = 0;
    if (s1 != 0 && m_q[s1-1].ld && (s1 - 1) < LR) s = 1;
    if (s2 != 0 && m_q[s2-1].ld && (s2 - 1) < LR) s = 1;
    return id_valid && s;
  endfunction

  task automatic m_reset();
    ent_t e;
    e.v = 0; e.a = 0; e.ld = 0;
    m_q.delete();
    for (int i = 0; i < PD; i++) m_q.push_back(e);
    m_cnt = 0;
  endtask

  task automatic m_update();
    bit   st = m_stall();
    ent_t e;
    if (st && !hold && m_cnt < CNT_MAX) m_cnt++;
    if (flush) begin
      foreach (m_q[i]) m_q[i].v = 0;
    end else if (!hold) begin
      e.v  = id_valid && id_write_en && (id_write_addr != 0) && !st;
      e.a  = int'(id_write_addr);
      e.ld = id_is_load;
      m_q.push_front(e);
      void'(m_q.pop_back());
    end
  endtask

  task automatic apply(input bit v, input bit re1, input int a1, input bit re2, input int a2,
                       input bit we, input int wa, input bit ld, input bit fl, input bit hd);
    id_valid = v; id_read_en_1 = re1; id_read_addr_1 = AW'(a1);
    id_read_en_2 = re2; id_read_addr_2 = AW'(a2);
    id_write_en = we; id_write_addr = AW'(wa); id_is_load = ld;
    flush = fl; hold = hd;
    #1;
    check_eq("sel1", fwd_sel_1, m_sel(re1, a1));
    check_eq("sel2", fwd_sel_2, m_sel(re2, a2));
    check_eq("stall", stall_req, m_stall());
    check_eq("count", stall_count, m_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    flush = 0; hold = 0; id_valid = 0; id_read_en_1 = 0; id_read_en_2 = 0;
    id_write_en = 0; id_is_load = 0; id_read_addr_1 = '0; id_read_addr_2 = '0; id_write_addr = '0;
    m_reset();
    @(negedge clk);
    check_eq("rst_sel1", fwd_sel_1, 0);
    check_eq("rst_sel2", fwd_sel_2, 0);
    check_eq("rst_stall", stall_req, 0);
    check_eq("rst_count", stall_count, 0);
    rst = 1'b0;

    // ALU write then dependent read: forward from EX
    apply(1, 0, 0, 0, 0, 1, 3, 0, 0, 0); tick();
    apply(1, 1, 3, 1, 4, 1, 10, 0, 0, 0);
    check_eq("t1_sel1", fwd_sel_1, 1);
    check_eq("t1_sel2", fwd_sel_2, 0);
    check_eq("t1_stall", stall_req, 0);
    tick();

    // Load-use: one bubble, then forward from MEM
    apply(1, 0, 0, 0, 0, 1, 5, 1, 0, 0); tick();
    apply(1, 1, 5, 1, 5, 1, 6, 0, 0, 0);
    check_eq("t2_stall0", stall_req, 1);
    check_eq("t2_sel0", fwd_sel_1, 1);
    tick();
    apply(1, 1, 5, 1, 5, 1, 6, 0, 0, 0);
    check_eq("t2_stall1", stall_req, 0);
    check_eq("t2_sel1", fwd_sel_1, 2);
    check_eq("t2_sel2", fwd_sel_2, 2);
    check_eq("t2_cnt", stall_count, 1);
    tick();

    // Youngest of two writes wins, retires after idle shifts
    apply(1, 0, 0, 0, 0, 1, 7, 0, 0, 0); tick();
    apply(1, 0, 0, 0, 0, 1, 7, 0, 0, 0); tick();
    apply(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    check_eq("t3_young", fwd_sel_1, 1);
    tick();
    idle(); idle(); idle();
    apply(1, 1, 7, 1, 7, 0, 0, 0, 0, 0);
    check_eq("t3_retired", fwd_sel_1, 0);
    tick();

    // Register 0 is never tracked
    apply(1, 0, 0, 0, 0, 1, 0, 0, 0, 0); tick();
    apply(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    check_eq("t4_sel", fwd_sel_1, 0);
    tick();
    apply(1, 0, 0, 0, 0, 1, 0, 1, 0, 0); tick();
    apply(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    check_eq("t4_nostall", stall_req, 0);
    tick();

    // Hold freezes entries and the counter
    apply(1, 0, 0, 0, 0, 1, 8, 1, 0, 0); tick();
    for (int k = 0; k < 3; k++) begin
      apply(1, 1, 8, 0, 0, 0, 0, 0, 0, 1);
      check_eq("t5_hold_stall", stall_req, 1);
      check_eq("t5_hold_cnt", stall_count, 1);
      tick();
    end
    apply(1, 1, 8, 0, 0, 0, 0, 0, 0, 0);
    check_eq("t5_rel_stall", stall_req, 1);
    tick();
    apply(1, 1, 8, 0, 0, 0, 0, 0, 0, 0);
    check_eq("t5_rel_cnt", stall_count, 2);
    check_eq("t5_rel_sel", fwd_sel_1, 2);
    check_eq("t5_rel_nostall", stall_req, 0);
    tick();

    // Flush during a stall with full entries
    apply(1, 0, 0, 0, 0, 1, 11, 0, 0, 0); tick();
    apply(1, 0, 0, 0, 0, 1, 12, 0, 0, 0); tick();
    apply(1, 0, 0, 0, 0, 1, 13, 1, 0, 0); tick();
    apply(1, 1, 13, 1, 11, 0, 0, 0, 1, 0);
    check_eq("t6_pre_stall", stall_req, 1);
    check_eq("t6_pre_sel2", fwd_sel_2, 3);
    tick();
    apply(1, 1, 13, 1, 11, 0, 0, 0, 0, 0);
    check_eq("t6_post_sel1", fwd_sel_1, 0);
    check_eq("t6_post_sel2", fwd_sel_2, 0);
    check_eq("t6_post_stall", stall_req, 0);
    check_eq("t6_post_cnt", stall_count, 3);
    tick();

    // Asynchronous reset mid-cycle
    apply(1, 0, 0, 0, 0, 1, 3, 0, 0, 0); tick();
    apply(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    check_eq("t6_pre_rst", fwd_sel_1, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_arst_sel", fwd_sel_1, 0);
    check_eq("t6_arst_cnt", stall_count, 0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;

    // Counter saturation
    for (int k = 0; k < CNT_MAX + 5; k++) begin
      apply(1, 0, 0, 0, 0, 1, 9, 1, 0, 0); tick();
      apply(1, 1, 9, 0, 0, 0, 0, 0, 0, 0); tick();
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("sat_cnt", stall_count, CNT_MAX);
    tick();

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      apply($urandom_range(0, 7) != 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 7),
            $urandom_range(0, 2) != 0, $urandom_range(0, 7),
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 7) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
